mem_access_unit: RTL

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit_if.sv | 32 +++
 rtl/mem_access_unit.sv | 126 ++++++++++++
 2 files changed

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: CPU-side request/response signals and data_memory
// strobes for mem_access_unit, bundled into one interface.
//   slave  : the access unit (consumes request + mem_rdata, drives the rest)
//   master : the environment (CPU driving the request, memory returning data)
interface mem_access_unit_if;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        busy;
    logic        done;
    logic        err;
    logic        mem_sel;
    logic        mem_str;
    logic        mem_ld;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  req, we, size, sign_ext, addr, wdata, mem_rdata,
        output rdata, busy, done, err, mem_sel, mem_str, mem_ld, mem_addr, mem_wdata
    );

    modport master (
        output req, we, size, sign_ext, addr, wdata, mem_rdata,
        input  rdata, busy, done, err, mem_sel, mem_str, mem_ld, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: byte/halfword/word load-store sequencer in front of a
// 1024-word data_memory. Sub-word stores are done read-modify-write.
// Ports:
//   clk    rising-edge clock (shared with data_memory)
//   clr_n  asynchronous active-low reset
//   bus    mem_access_unit_if.slave: req/we/size/sign_ext/addr/wdata in,
//          rdata/busy/done/err out, mem_sel/mem_str/mem_ld/mem_addr/mem_wdata
//          to the memory, mem_rdata back from it
module mem_access_unit (
    input  logic             clk,
    input  logic             clr_n,
    mem_access_unit_if.slave bus
);
    typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, DONE, ERR} state_t;

    state_t      state;
    logic [1:0]  size_q;
    logic        sext_q;
    logic [11:0] addr_q;     // addresses wrap at 4 KiB, upper bits never kept
    logic [31:0] wdata_q;
    logic [31:0] merge_q;
    logic [31:0] rdata_q;
    logic        busy_q;
    logic        done_q;
    logic        err_q;

    logic        misalign;
    logic        bad;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_val;
    logic [31:0] merge_val;

    assign misalign = (bus.size == 2'b01 && bus.addr[0]) ||
                      (bus.size == 2'b10 && bus.addr[1:0] != 2'b00);
    assign bad      = misalign || bus.size == 2'b11;

    // Little-endian lane pick from the memory word
    assign rd_byte = bus.mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    assign rd_half = bus.mem_rdata[{addr_q[1], 4'b0000} +: 16];

    always_comb begin
        case (size_q)
            2'b00:   load_val = {{24{sext_q & rd_byte[7]}}, rd_byte};
            2'b01:   load_val = {{16{sext_q & rd_half[15]}}, rd_half};
            default: load_val = bus.mem_rdata;
        endcase
    end

    // Old word with the target lane(s) overwritten by the store data
    always_comb begin
        merge_val = bus.mem_rdata;
        if (size_q == 2'b00)
            merge_val[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        else
            merge_val[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end

    // Memory strobes depend on state alone
    assign bus.mem_ld    = (state == LOAD) || (state == RMW_RD);
    assign bus.mem_str   = (state == WRITE);
    assign bus.mem_sel   = bus.mem_ld || bus.mem_str;
    assign bus.mem_addr  = addr_q[11:2];
    assign bus.mem_wdata = (state != WRITE)  ? '0 :
                           (size_q == 2'b10) ? wdata_q : merge_q;

    assign bus.rdata = rdata_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.err   = err_q;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state   <= IDLE;
            size_q  <= '0;
            sext_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            merge_q <= '0;
            rdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                IDLE: if (bus.req) begin
                    size_q  <= bus.size;
                    sext_q  <= bus.sign_ext;
                    addr_q  <= bus.addr[11:0];
                    wdata_q <= bus.wdata;
                    busy_q  <= 1'b1;
                    // we only steers the next state, so it is not kept
                    if (bad) begin
                        state  <= ERR;
                        done_q <= 1'b1;
                        err_q  <= 1'b1;
                    end else if (!bus.we)
                        state <= LOAD;
                    else if (bus.size == 2'b10)
                        state <= WRITE;
                    else
                        state <= RMW_RD;
                end
                LOAD: begin
                    rdata_q <= load_val;
                    state   <= DONE;
                    done_q  <= 1'b1;
                end
                RMW_RD: begin
                    merge_q <= merge_val;
                    state   <= WRITE;
                end
                WRITE: begin
                    state  <= DONE;
                    done_q <= 1'b1;
                end
                default: begin   // DONE, ERR
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end
endmodule
